// File: rtl/wb_debug_pkg.sv
// Shared definitions for the two-master debug/control Wishbone arbiter.
package wb_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_TOUT = 2'd3
    } state_e;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 20;
    localparam int WB_SEL_WIDTH  = 4;

endpackage

// File: rtl/wb_debug_arbiter.sv
// Round-robin arbiter merging the control master (m0) and debug master (m1)
// onto one Wishbone bus, with per-master lock and a slave-timeout watchdog.
module wb_debug_arbiter
    import wb_debug_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int SEL_WIDTH  = WB_SEL_WIDTH,
    parameter int TIMEOUT    = 255,
    parameter int TCNT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                  m0_lock_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                  m1_lock_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [1:0]            grant_o,
    output logic [TCNT_WIDTH-1:0] timeout_count_o
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;     // 1 = m1 holds (or last held) the bus
    logic                    rr_last_q, rr_last_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [TCNT_WIDTH-1:0]   tcnt_q, tcnt_d;

    logic                    cur_cyc, cur_stb, cur_we, cur_lock;
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic [SEL_WIDTH-1:0]    cur_sel;
    logic                    s_resp;

    assign cur_cyc  = owner_q ? m1_cyc_i  : m0_cyc_i;
    assign cur_stb  = owner_q ? m1_stb_i  : m0_stb_i;
    assign cur_we   = owner_q ? m1_we_i   : m0_we_i;
    assign cur_lock = owner_q ? m1_lock_i : m0_lock_i;
    assign cur_adr  = owner_q ? m1_adr_i  : m0_adr_i;
    assign cur_dat  = owner_q ? m1_dat_i  : m0_dat_i;
    assign cur_sel  = owner_q ? m1_sel_i  : m0_sel_i;
    assign s_resp   = s_ack_i | s_err_i | s_rty_i;

    assign m0_dat_o        = s_dat_i;
    assign m1_dat_o        = s_dat_i;
    assign grant_o         = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign timeout_count_o = tcnt_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wd_d      = '0;
        tcnt_d    = tcnt_q;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_rty_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || rr_last_q)) begin
                    state_d = ST_GNT0;
                    owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_GNT1;
                    owner_d = 1'b1;
                end
            end

            ST_GNT0, ST_GNT1: begin
                s_cyc_o = cur_cyc;
                s_stb_o = cur_stb;
                s_we_o  = cur_we;
                s_adr_o = cur_adr;
                s_dat_o = cur_dat;
                s_sel_o = cur_sel;
                if (owner_q) begin
                    m1_ack_o = s_ack_i;
                    m1_err_o = s_err_i;
                    m1_rty_o = s_rty_i;
                end else begin
                    m0_ack_o = s_ack_i;
                    m0_err_o = s_err_i;
                    m0_rty_o = s_rty_i;
                end
                if (!cur_cyc && !cur_lock) begin
                    state_d   = ST_IDLE;
                    rr_last_d = owner_q;
                end else if (TIMEOUT > 0) begin
                    // A response on the expiry cycle wins over the watchdog.
                    if (s_resp || !(cur_cyc && cur_stb)) begin
                        wd_d = '0;
                    end else if (wd_q == WD_LAST) begin
                        state_d = ST_TOUT;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end

            ST_TOUT: begin
                m0_err_o = !owner_q;
                m1_err_o = owner_q;
                tcnt_d   = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
                if (cur_cyc || cur_lock) begin
                    state_d = owner_q ? ST_GNT1 : ST_GNT0;
                end else begin
                    state_d   = ST_IDLE;
                    rr_last_d = owner_q;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wd_q      <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            wd_q      <= wd_d;
            tcnt_q    <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_wb_debug_arbiter.sv
// Directed bench for wb_debug_arbiter (TIMEOUT=16, TCNT_WIDTH=8): arbitration,
// single read, watchdog, lock, ack-vs-expiry, counter saturation, async reset.
module tb_wb_debug_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TW = 8;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    grant_o;
    logic [TW-1:0] timeout_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    wb_debug_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .TIMEOUT(16), .TCNT_WIDTH(TW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_lock_i(m0_lock_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_lock_i(m1_lock_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_count_o(timeout_count_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc_start;
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid;
        @(negedge clk_i);
    endtask

    task automatic idle_all;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_lock_i = 0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_lock_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic test_reset;
        idle_all();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", s_cyc_o, s_stb_o); end
        checks++; if (timeout_count_o !== 8'd0) begin failures++; $display("FAIL reset_tcnt: got %0d expected 0", timeout_count_o); end
        checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin failures++; $display("FAIL reset_resp: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        $display("test_reset done");
    endtask

    task automatic test_arbitration;
        cyc_start();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 20'h00100;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 20'h00200;
        mid();
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL arb_latency: got grant=%b s_cyc=%b expected 00/0", grant_o, s_cyc_o); end
        cyc_start(); s_ack_i = 1; s_dat_i = 32'h11112222;
        mid();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL arb_first_tie: got %b expected 01", grant_o); end
        checks++; if (s_adr_o !== 20'h00100) begin failures++; $display("FAIL arb_adr0: got %h expected 00100", s_adr_o); end
        checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL arb_ack0: got m0=%b m1=%b expected 1/0", m0_ack_o, m1_ack_o); end
        cyc_start(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        mid();
        checks++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL arb_drop: got grant=%b s_cyc=%b expected 01/0", grant_o, s_cyc_o); end
        cyc_start(); m0_cyc_i = 1; m0_stb_i = 1;
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL arb_dead_cycle: got %b expected 00", grant_o); end
        cyc_start(); s_ack_i = 1;
        mid();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL arb_second_tie: got %b expected 10", grant_o); end
        checks++; if (s_adr_o !== 20'h00200 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL arb_ack1: got adr=%h m1=%b m0=%b expected 00200/1/0", s_adr_o, m1_ack_o, m0_ack_o); end
        cyc_start(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        mid();
        cyc_start(); m1_cyc_i = 1; m1_stb_i = 1;
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL arb_dead_cycle2: got %b expected 00", grant_o); end
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL arb_alternate: got %b expected 01", grant_o); end
        cyc_start(); idle_all();
        mid();
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL arb_release: got %b expected 00", grant_o); end
        $display("test_arbitration done");
    endtask

    task automatic test_single_read;
        cyc_start(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 20'h00010; m1_sel_i = 4'hF;
        mid();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rd_latency: got s_cyc=%b expected 0", s_cyc_o); end
        cyc_start();
        mid();
        checks++; if (s_cyc_o !== 1'b1 || grant_o !== 2'b10 || s_adr_o !== 20'h00010 || s_we_o !== 1'b0) begin failures++; $display("FAIL rd_grant: got cyc=%b grant=%b adr=%h we=%b expected 1/10/00010/0", s_cyc_o, grant_o, s_adr_o, s_we_o); end
        cyc_start();
        mid();
        checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL rd_no_early_ack: got %b expected 0", m1_ack_o); end
        cyc_start(); s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
        mid();
        checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_ack: got ack=%b dat=%h expected 1/deadbeef", m1_ack_o, m1_dat_o); end
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL rd_other_ack: got %b expected 0", m0_ack_o); end
        cyc_start(); idle_all();
        mid();
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL rd_release: got grant=%b cyc=%b expected 00/0", grant_o, s_cyc_o); end
        $display("test_single_read done");
    endtask

    task automatic test_timeout;
        cyc_start(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 20'hFFFFF;
        m0_dat_i = 32'hCAFEF00D; m0_sel_i = 4'hF;
        mid();
        for (int k = 1; k <= 16; k++) begin
            cyc_start();
            mid();
            checks++; if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL tout_early cycle %0d: got err=%b cyc=%b expected 0/1", k, m0_err_o, s_cyc_o); end
        end
        cyc_start();
        mid();
        checks++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m0_rty_o !== 1'b0) begin failures++; $display("FAIL tout_err: got err=%b ack=%b rty=%b expected 1/0/0", m0_err_o, m0_ack_o, m0_rty_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL tout_s_cyc: got %b%b expected 00", s_cyc_o, s_stb_o); end
        cyc_start(); m0_cyc_i = 0; m0_stb_i = 0;
        mid();
        checks++; if (m0_err_o !== 1'b0) begin failures++; $display("FAIL tout_single_pulse: got %b expected 0", m0_err_o); end
        checks++; if (timeout_count_o !== 8'd1) begin failures++; $display("FAIL tout_count: got %0d expected 1", timeout_count_o); end
        cyc_start(); idle_all();
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL tout_release: got %b expected 00", grant_o); end
        $display("test_timeout done");
    endtask

    task automatic test_lock;
        cyc_start(); m1_cyc_i = 1; m1_stb_i = 1; m1_lock_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
        mid();
        cyc_start(); s_ack_i = 1;
        mid();
        checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1) begin failures++; $display("FAIL lock_first: got grant=%b ack=%b expected 10/1", grant_o, m1_ack_o); end
        for (int k = 0; k < 3; k++) begin
            cyc_start(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
            mid();
            checks++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL lock_hold gap %0d: got grant=%b cyc=%b expected 10/0", k, grant_o, s_cyc_o); end
        end
        cyc_start(); m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        mid();
        checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL lock_second: got grant=%b m1=%b m0=%b expected 10/1/0", grant_o, m1_ack_o, m0_ack_o); end
        cyc_start(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_lock_i = 0;
        mid();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL lock_drop: got %b expected 10", grant_o); end
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL lock_dead: got %b expected 00", grant_o); end
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL lock_m0_granted: got %b expected 01", grant_o); end
        cyc_start(); idle_all();
        mid();
        cyc_start();
        mid();
        $display("test_lock done");
    endtask

    task automatic test_ack_at_expiry;
        cyc_start(); m0_cyc_i = 1; m0_stb_i = 1;
        mid();
        for (int k = 1; k <= 15; k++) begin
            cyc_start();
            mid();
        end
        cyc_start(); s_ack_i = 1;
        mid();
        checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) begin failures++; $display("FAIL expiry_ack: got ack=%b err=%b expected 1/0", m0_ack_o, m0_err_o); end
        cyc_start(); s_ack_i = 0;
        mid();
        checks++; if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL expiry_no_tout: got err=%b cyc=%b expected 0/1", m0_err_o, s_cyc_o); end
        checks++; if (timeout_count_o !== 8'd1) begin failures++; $display("FAIL expiry_count: got %0d expected 1", timeout_count_o); end
        cyc_start(); idle_all();
        mid();
        cyc_start();
        mid();
        $display("test_ack_at_expiry done");
    endtask

    task automatic test_saturation;
        int pulses = 0;
        int cycles = 0;
        cyc_start(); m0_cyc_i = 1; m0_stb_i = 1;
        mid();
        while (pulses < 300 && cycles < 6000) begin
            cyc_start();
            mid();
            cycles++;
            if (m0_err_o === 1'b1) begin
                pulses++;
                if (pulses == 200) begin
                    checks++; if (timeout_count_o !== 8'd200) begin failures++; $display("FAIL sat_mid: got %0d expected 200", timeout_count_o); end
                end
            end
        end
        checks++; if (pulses != 300) begin failures++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
        cyc_start(); idle_all();
        mid();
        checks++; if (timeout_count_o !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d expected 255", timeout_count_o); end
        cyc_start();
        mid();
        $display("test_saturation done");
    endtask

    task automatic test_async_reset;
        cyc_start(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 20'h00040;
        mid();
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL arst_pre: got grant=%b cyc=%b expected 10/1", grant_o, s_cyc_o); end
        #2;
        s_ack_i = 1;
        rst_n_i = 1'b0;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin failures++; $display("FAIL arst_async: got cyc=%b grant=%b expected 0/00", s_cyc_o, grant_o); end
        checks++; if (m1_ack_o !== 1'b0 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL arst_no_completion: got m1=%b m0=%b expected 0/0", m1_ack_o, m0_ack_o); end
        checks++; if (timeout_count_o !== 8'd0) begin failures++; $display("FAIL arst_tcnt: got %0d expected 0", timeout_count_o); end
        s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        mid();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL arst_release: got %b expected 00", grant_o); end
        cyc_start();
        mid();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL arst_tie: got %b expected 01", grant_o); end
        cyc_start(); idle_all();
        mid();
        $display("test_async_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish expected finish before 200000");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_single_read();
        test_timeout();
        test_lock();
        test_ack_at_expiry();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
